// File: rtl/seq_multdiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: FSM encoding,
// iteration count and the two's-complement magnitude helper.
package seq_multdiv_pkg;

    localparam int ITERS = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    // Magnitude of a two's-complement word; INT_MIN maps to 0x80000000 unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/seq_multdiv_add_sub.sv
// 32-bit adder/subtractor shared with the Booth accumulate path.
module seq_multdiv_add_sub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        ovf
);

    logic [31:0] b_eff_s;

    assign b_eff_s = sub ? ~b : b;
    assign sum     = a + b_eff_s + {31'd0, sub};
    assign ovf     = (a[31] == b_eff_s[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/seq_multdiv.sv
// Multi-cycle signed 32-bit multiplier (radix-2 Booth) and restoring divider
// with a fixed 33-cycle latency from the start edge to the result pulse.
module seq_multdiv #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    import seq_multdiv_pkg::*;

    state_e      state_r;
    logic [4:0]  count_r;
    logic        is_div_r;
    logic        div_neg_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] p_hi_r;
    logic [31:0] p_lo_r;
    logic        q_m1_r;

    logic        start_s;
    logic [31:0] mag_b_s;
    logic        booth_sub_s;
    logic        booth_en_s;
    logic [31:0] booth_sum_s;
    logic        unused_ovf_s;
    logic [31:0] booth_hi_s;
    logic [32:0] rem_shift_s;
    logic [32:0] rem_trial_s;
    logic [31:0] fin_result_s;
    logic        fin_exc_s;

    assign start_s     = ctrl_MULT | ctrl_DIV;
    assign mag_b_s     = abs32(b_r);
    assign booth_sub_s = p_lo_r[0] & ~q_m1_r;
    assign booth_en_s  = p_lo_r[0] ^ q_m1_r;
    assign busy        = (state_r != S_IDLE);

    seq_multdiv_add_sub u_add_sub (
        .a   (p_hi_r),
        .b   (a_r),
        .sub (booth_sub_s),
        .sum (booth_sum_s),
        .ovf (unused_ovf_s)
    );

    // Next-step datapath values and the FINISH result/exception selection.
    always_comb begin
        booth_hi_s   = booth_en_s ? booth_sum_s : p_hi_r;
        // In divide mode p_hi_r holds the partial remainder, p_lo_r the dividend/quotient.
        rem_shift_s  = {p_hi_r, p_lo_r[31]};
        rem_trial_s  = rem_shift_s - {1'b0, mag_b_s};
        fin_result_s = 32'd0;
        fin_exc_s    = 1'b0;
        if (!is_div_r) begin
            fin_result_s = p_lo_r;
            fin_exc_s    = (p_hi_r != {32{p_lo_r[31]}});
        end else if (b_r == 32'd0) begin
            fin_result_s = 32'd0;
            fin_exc_s    = 1'b1;
        end else if ((a_r == INT_MIN) && (b_r == 32'hFFFF_FFFF)) begin
            fin_result_s = INT_MIN;
            fin_exc_s    = 1'b1;
        end else begin
            fin_result_s = div_neg_r ? (32'd0 - p_lo_r) : p_lo_r;
            fin_exc_s    = 1'b0;
        end
    end

    // FSM, iteration datapath and registered outputs; a start always wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= S_IDLE;
            count_r        <= 5'd0;
            is_div_r       <= 1'b0;
            div_neg_r      <= 1'b0;
            a_r            <= 32'd0;
            b_r            <= 32'd0;
            p_hi_r         <= 32'd0;
            p_lo_r         <= 32'd0;
            q_m1_r         <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start_s) begin
                state_r   <= S_RUN;
                count_r   <= 5'd0;
                is_div_r  <= ~ctrl_MULT;
                div_neg_r <= data_operandA[31] ^ data_operandB[31];
                a_r       <= data_operandA;
                b_r       <= data_operandB;
                p_hi_r    <= 32'd0;
                q_m1_r    <= 1'b0;
                p_lo_r    <= ctrl_MULT ? data_operandB : abs32(data_operandA);
            end else begin
                case (state_r)
                    S_IDLE: begin
                        state_r <= S_IDLE;
                    end
                    S_RUN: begin
                        if (is_div_r) begin
                            if (!rem_trial_s[32]) begin
                                p_hi_r <= rem_trial_s[31:0];
                                p_lo_r <= {p_lo_r[30:0], 1'b1};
                            end else begin
                                p_hi_r <= rem_shift_s[31:0];
                                p_lo_r <= {p_lo_r[30:0], 1'b0};
                            end
                        end else begin
                            p_hi_r <= {booth_hi_s[31], booth_hi_s[31:1]};
                            p_lo_r <= {booth_hi_s[0], p_lo_r[31:1]};
                            q_m1_r <= p_lo_r[0];
                        end
                        count_r <= count_r + 5'd1;
                        if (count_r == 5'(ITERS - 1)) begin
                            state_r <= S_FINISH;
                        end
                    end
                    S_FINISH: begin
                        data_result    <= fin_result_s;
                        data_exception <= fin_exc_s;
                        data_resultRDY <= 1'b1;
                        state_r        <= S_IDLE;
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_multdiv.sv
// Directed-vector bench for seq_multdiv: results, exceptions, latency, abort,
// start priority and asynchronous reset behaviour.
module tb_seq_multdiv;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] prev_result = 32'd0;

    seq_multdiv #(.WIDTH(32), .ITERS(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a start for exactly one edge; returns #1 after that edge (E0).
    task automatic launch(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        int lat = 0;
        int busy_cnt = 0;
        launch(m, d, a, b);
        check_value({tag, " hold"}, data_result, prev_result);
        if (busy) busy_cnt = 1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
        check_value({tag, " latency"}, 32'(lat), 32'd33);
        check_value({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
        check_value({tag, " busy_at_rdy"}, {31'd0, busy}, 32'd0);
        check_value({tag, " result"}, data_result, exp_res);
        check_value({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
        @(posedge clock);
        #1;
        check_value({tag, " rdy_width"}, {31'd0, data_resultRDY}, 32'd0);
        prev_result = exp_res;
    endtask

    initial begin
        int pulses;
        int lat;

        #2;
        reset_n = 1'b0;
        #1;
        check_value("rst result", data_result, 32'd0);
        check_value("rst exc", {31'd0, data_exception}, 32'd0);
        check_value("rst rdy", {31'd0, data_resultRDY}, 32'd0);
        check_value("rst busy", {31'd0, busy}, 32'd0);
        #20;
        reset_n = 1'b1;

        run_op("mul 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mul 2^16*2^16", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("mul 2^16*-2^16", 1'b1, 1'b0, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b1);
        run_op("div -100/7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
        run_op("div 5/0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
        run_op("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("div min/2", 1'b0, 1'b1, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0);
        run_op("both 6,7", 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0);

        // Abort a multiply with a divide issued on the tenth edge.
        pulses = 0;
        lat = 0;
        launch(1'b1, 1'b0, 32'd6, 32'd7);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        launch(1'b0, 1'b1, 32'd100, 32'd9);
        check_value("abort hold", data_result, prev_result);
        for (int k = 1; k <= 45; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                pulses++;
                if (lat == 0) lat = k;
            end
        end
        check_value("abort pulses", 32'(pulses), 32'd1);
        check_value("abort latency", 32'(lat), 32'd33);
        check_value("abort result", data_result, 32'd11);
        check_value("abort exc", {31'd0, data_exception}, 32'd0);
        prev_result = 32'd11;

        // Asynchronous reset in the middle of a multiply.
        launch(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0010);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_value("midrst result", data_result, 32'd0);
        check_value("midrst exc", {31'd0, data_exception}, 32'd0);
        check_value("midrst rdy", {31'd0, data_resultRDY}, 32'd0);
        check_value("midrst busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY || busy) pulses++;
        end
        check_value("midrst quiet", 32'(pulses), 32'd0);
        prev_result = 32'd0;

        run_op("mul 3*4", 1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seq_multdiv.md
# seq_multdiv

Multi-cycle signed 32-bit multiplier/divider in the execute stage, alongside the single-cycle ALU. It drives one instance of the team's 32-bit adder/subtractor every cycle with operands and the add/subtract select, and consumes its sum to update the partial product. The pipeline stalls on `busy` and retires the instruction when `data_resultRDY` pulses. Overflow and divide-by-zero are reported on `data_exception` for the `$rstatus` write path.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `ITERS`, 32, iteration count; must equal `WIDTH`.

Ports:
- `clock` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `data_operandA` in 32: multiplicand or dividend, two's complement; sampled on the start edge only.
- `data_operandB` in 32: multiplier or divisor; sampled on the start edge only.
- `ctrl_MULT` in 1: single-cycle start pulse for multiply.
- `ctrl_DIV` in 1: single-cycle start pulse for divide.
- `data_result` out 32: low 32 bits of the product, or the quotient truncated toward zero.
- `data_exception` out 1: overflow, divide-by-zero, or `0x80000000 / -1`.
- `data_resultRDY` out 1: one-cycle pulse; result and exception are valid from this cycle on.
- `busy` out 1: high while the FSM is not in IDLE.

## Operation

- Reset (async, any state): FSM goes to IDLE and the counter clears. `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0.
- FSM states: IDLE → RUN → FINISH → IDLE.
- Start edge: edge on which `ctrl_MULT` or `ctrl_DIV` is sampled high.
  - If both are high, MULT wins.
  - A start in any state, including RUN and FINISH, aborts the current operation, latches the new operands, and enters RUN with count=0.
  - An aborted operation never raises `data_resultRDY`.
- Multiply: radix-2 Booth on a 65-bit {P_hi, P_lo, q₋₁} register.
  - Each RUN cycle, inspect {P_lo[0], q₋₁}:
    - 01: `add_sub` computes P_hi + A (sub=0).
    - 10: `add_sub` computes P_hi − A (sub=1).
    - 00/11: pass P_hi unchanged.
  - Then arithmetic-shift the whole register right by 1.
  - The `add_sub` `ovf` output is ignored.
- Divide: restoring division on magnitudes |A| and |B|.
  - Uses a 33-bit partial remainder and a local 33-bit subtract.
  - One quotient bit per RUN cycle.
  - Result sign = A[31] XOR B[31]; the remainder is discarded.
- FINISH, multiply:
  - `data_result` = P_lo.
  - Exception = the upper 33 bits of the 64-bit product are not all equal.
- FINISH, divide:
  - B=0: result 0, exception 1.
  - A=0x80000000 and B=0xFFFFFFFF: result 0x80000000, exception 1.
  - Otherwise: sign-corrected quotient, exception 0.
- `data_result` and `data_exception` hold their values until the next FINISH or reset. They do not change on a start.

## Timing

- The start edge is E0. RUN iterations occur on edges E1..E32.
- Counter 31 at E32 moves the FSM to FINISH.
- On E33, result and exception are registered, `data_resultRDY` goes to 1, and the FSM returns to IDLE.
- `data_resultRDY` is high only in the cycle after E33. Fixed latency is 33 cycles, independent of operand values.
- `busy` is high from E0 through E33.
- Back-to-back operation: a start sampled together with `data_resultRDY` begins a new operation. It does not cancel the pulse already issued.
- `reset_n` deasserting mid-RUN leaves the FSM in IDLE with no pulse.

## Structure

- Shared package holds:
  - the FSM state enum: `S_IDLE`, `S_RUN`, `S_FINISH`;
  - `ITERS`;
  - `INT_MIN` = 32'h80000000.
- Sub-module: one `add_sub` instance for the Booth accumulate path. No other sub-modules; the divider subtractor is inline.
- All state lives in a single always block with async reset. Operand magnitude and sign logic is combinational.

## Test plan

- MULT, A=7, B=−3 (0xFFFFFFFD) → `data_result`=0xFFFFFFEB, exception 0, `data_resultRDY` exactly 33 cycles after the start edge, `busy` high for 33 cycles.
- MULT, A=B=0x00010000 → result 0x00000000, exception 1.
- MULT, A=0x00010000, B=0xFFFF0000 → result 0x00000000, exception 1.
- DIV, A=−100 (0xFFFFFF9C), B=7 → result 0xFFFFFFF2 (−14), exception 0.
- DIV, A=5, B=0 → result 0, exception 1.
- DIV, A=0x80000000, B=0xFFFFFFFF → result 0x80000000, exception 1.
- DIV, A=0x80000000, B=2 → result 0xC0000000, exception 0.
- Start MULT 6×7, then at cycle 10 start DIV 100/9 → no pulse for the multiply; a single pulse 33 cycles after the second start with result 11.
- `ctrl_MULT` and `ctrl_DIV` both high with A=6, B=7 → result 42, which confirms MULT priority.
- Assert `reset_n` low at cycle 20 of a multiply → all outputs 0 immediately and no pulse afterwards.
- A new MULT 3×4 after that reset → result 12.
